// File: rtl/sonic_pkg.sv
`default_nettype none
// ============================================================================
// Module   : sonic_pkg
// Purpose  : Shared types, default timing constants and width helpers for the
//            ultrasonic trigger scheduler.
// Revision : 1.0 - initial release
// ============================================================================
package sonic_pkg;

  // Scheduler phases: arbitrate, fire trigger, watch echo, quiet guard
  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_TRIG  = 2'd1,
    ST_ECHO  = 2'd2,
    ST_GUARD = 2'd3
  } sonic_state_e;

  // Default timing, derived from a 50 MHz system clock
  localparam int unsigned C_CLK_HZ         = 50_000_000;
  localparam int unsigned C_TRIG_CYCLES    = C_CLK_HZ / 100_000;     // 10 us
  localparam int unsigned C_TIMEOUT_CYCLES = (C_CLK_HZ / 100) * 3;   // 30 ms
  localparam int unsigned C_GUARD_CYCLES   = C_CLK_HZ / 100;         // 10 ms

  // Group index width: max(1, clog2(n))
  function automatic int cw_of(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

  // Largest of three values, used to size the shared phase counter
  function automatic int max3(input int a, input int b, input int c);
    int m;
    m = a;
    if (b > m) m = b;
    if (c > m) m = c;
    return m;
  endfunction

endpackage
`default_nettype wire

// File: rtl/sonic_trigger_scheduler_if.sv
`default_nettype none
// ============================================================================
// Module   : sonic_trigger_scheduler_if
// Purpose  : Control, echo and measurement-result bundle between the sensor
//            network (master) and the trigger scheduler (slave).
// Revision : 1.0 - initial release
// ============================================================================
interface sonic_trigger_scheduler_if
  import sonic_pkg::*;
#(
  parameter int NUM_GROUPS = 2
);
  localparam int CW = cw_of(NUM_GROUPS);

  logic                  enable;
  logic [NUM_GROUPS-1:0] group_mask;
  logic [NUM_GROUPS-1:0] echo_any;
  logic [NUM_GROUPS-1:0] trig;
  logic [CW-1:0]         active_grp;
  logic                  busy;
  logic                  meas_done;
  logic [CW-1:0]         meas_grp;
  logic                  meas_timeout;

  modport master (
    output enable, group_mask, echo_any,
    input  trig, active_grp, busy, meas_done, meas_grp, meas_timeout
  );

  modport slave (
    input  enable, group_mask, echo_any,
    output trig, active_grp, busy, meas_done, meas_grp, meas_timeout
  );

endinterface
`default_nettype wire

// File: rtl/sonic_rr_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : sonic_rr_arbiter
// Purpose  : Combinational round-robin pick: first eligible group strictly
//            after the last-served one, wrapping; the last-served group itself
//            is the final candidate so a single-bit mask repeats.
// Revision : 1.0 - initial release
// ============================================================================
module sonic_rr_arbiter #(
  parameter int NUM_GROUPS = 2,
  parameter int CW         = 1
) (
  input  wire logic [NUM_GROUPS-1:0] i_mask,
  input  wire logic [CW-1:0]         i_last,
  output logic                       o_valid,
  output logic [CW-1:0]              o_grp
);

  // Scan from the farthest candidate to the nearest so the nearest wins
  always_comb begin
    o_valid = |i_mask;
    o_grp   = i_last;
    for (int k = NUM_GROUPS; k >= 1; k--) begin
      if (i_mask[(int'(i_last) + k) % NUM_GROUPS]) begin
        o_grp = CW'((int'(i_last) + k) % NUM_GROUPS);
      end
    end
  end

endmodule
`default_nettype wire

// File: rtl/sonic_trigger_scheduler.sv
`default_nettype none
// ============================================================================
// Module   : sonic_trigger_scheduler
// Purpose  : Mask-controlled, echo-aware round-robin trigger sequencer for the
//            ultrasonic sensor groups. One group is fired at a time; its echo
//            is watched with a timeout, then a guard interval keeps groups
//            from cross-talking.
// Revision : 1.0 - initial release
// ============================================================================
module sonic_trigger_scheduler
  import sonic_pkg::*;
#(
  parameter int NUM_GROUPS     = 2,
  parameter int TRIG_CYCLES    = int'(C_TRIG_CYCLES),
  parameter int TIMEOUT_CYCLES = int'(C_TIMEOUT_CYCLES),
  parameter int GUARD_CYCLES   = int'(C_GUARD_CYCLES)
) (
  input  wire logic                 CLOCK_50,
  input  wire logic                 reset_n,
  sonic_trigger_scheduler_if.slave  bus
);

  localparam int CW    = cw_of(NUM_GROUPS);
  localparam int CNT_W = $clog2(max3(TRIG_CYCLES, TIMEOUT_CYCLES, GUARD_CYCLES) + 1);

  localparam logic [CNT_W-1:0] C_TRIG_LAST    = CNT_W'(TRIG_CYCLES - 1);
  localparam logic [CNT_W-1:0] C_TIMEOUT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);
  localparam logic [CNT_W-1:0] C_GUARD_LAST   = CNT_W'(GUARD_CYCLES - 1);

  sonic_state_e          r_state, w_state_nxt;
  logic [CNT_W-1:0]      r_cnt, w_cnt_nxt;
  logic                  r_seen, w_seen_nxt;
  logic [CW-1:0]         r_active, w_active_nxt;
  logic [CW-1:0]         r_last, w_last_nxt;
  logic [NUM_GROUPS-1:0] r_sync1, r_sync2;
  logic                  r_meas_done, r_meas_to;
  logic [CW-1:0]         r_meas_grp;

  logic                  w_done, w_to;
  logic                  w_echo;
  logic                  w_arb_valid;
  logic [CW-1:0]         w_arb_grp;
  logic [NUM_GROUPS-1:0] w_trig;

  sonic_rr_arbiter #(
    .NUM_GROUPS (NUM_GROUPS),
    .CW         (CW)
  ) u_arb (
    .i_mask  (bus.group_mask),
    .i_last  (r_last),
    .o_valid (w_arb_valid),
    .o_grp   (w_arb_grp)
  );

  // Two-flop synchronizer on every group's combined echo line
  always_ff @(posedge CLOCK_50 or negedge reset_n) begin
    if (!reset_n) begin
      r_sync1 <= '0;
      r_sync2 <= '0;
    end else begin
      r_sync1 <= bus.echo_any;
      r_sync2 <= r_sync1;
    end
  end

  assign w_echo = r_sync2[r_active];

  // State, counter and group registers; last-served starts at the top group
  always_ff @(posedge CLOCK_50 or negedge reset_n) begin
    if (!reset_n) begin
      r_state  <= ST_IDLE;
      r_cnt    <= '0;
      r_seen   <= 1'b0;
      r_active <= '0;
      r_last   <= CW'(NUM_GROUPS - 1);
    end else begin
      r_state  <= w_state_nxt;
      r_cnt    <= w_cnt_nxt;
      r_seen   <= w_seen_nxt;
      r_active <= w_active_nxt;
      r_last   <= w_last_nxt;
    end
  end

  // Next-state logic; the counter is shared by all timed phases
  always_comb begin
    w_state_nxt  = r_state;
    w_cnt_nxt    = r_cnt;
    w_seen_nxt   = r_seen;
    w_active_nxt = r_active;
    w_last_nxt   = r_last;
    w_done       = 1'b0;
    w_to         = 1'b0;
    case (r_state)
      ST_IDLE: begin
        // enable and mask only matter here, so a running group always finishes
        if (bus.enable && w_arb_valid) begin
          w_active_nxt = w_arb_grp;
          w_last_nxt   = w_arb_grp;
          w_cnt_nxt    = '0;
          w_state_nxt  = ST_TRIG;
        end
      end
      ST_TRIG: begin
        if (r_cnt == C_TRIG_LAST) begin
          w_cnt_nxt   = '0;
          w_seen_nxt  = 1'b0;
          w_state_nxt = ST_ECHO;
        end else begin
          w_cnt_nxt = r_cnt + 1'b1;
        end
      end
      ST_ECHO: begin
        w_cnt_nxt = r_cnt + 1'b1;
        if (w_echo) begin
          w_seen_nxt = 1'b1;
        end
        // Echo completion takes priority over a coincident timeout
        if (r_seen && !w_echo) begin
          w_done      = 1'b1;
          w_cnt_nxt   = '0;
          w_state_nxt = ST_GUARD;
        end else if (r_cnt == C_TIMEOUT_LAST) begin
          w_done      = 1'b1;
          w_to        = 1'b1;
          w_cnt_nxt   = '0;
          w_state_nxt = ST_GUARD;
        end
      end
      ST_GUARD: begin
        if (r_cnt == C_GUARD_LAST) begin
          w_cnt_nxt   = '0;
          w_state_nxt = ST_IDLE;
        end else begin
          w_cnt_nxt = r_cnt + 1'b1;
        end
      end
      default: begin
        w_state_nxt = ST_IDLE;
        w_cnt_nxt   = '0;
      end
    endcase
  end

  // Measurement result registers; group and status held until the next strobe
  always_ff @(posedge CLOCK_50 or negedge reset_n) begin
    if (!reset_n) begin
      r_meas_done <= 1'b0;
      r_meas_to   <= 1'b0;
      r_meas_grp  <= '0;
    end else begin
      r_meas_done <= w_done;
      if (w_done) begin
        r_meas_to  <= w_to;
        r_meas_grp <= r_active;
      end
    end
  end

  // Trigger decoded from state so an asynchronous reset drops it at once
  always_comb begin
    w_trig = '0;
    for (int g = 0; g < NUM_GROUPS; g++) begin
      w_trig[g] = (r_state == ST_TRIG) && (r_active == CW'(g));
    end
  end

  assign bus.trig         = w_trig;
  assign bus.active_grp   = r_active;
  assign bus.busy         = (r_state != ST_IDLE);
  assign bus.meas_done    = r_meas_done;
  assign bus.meas_grp     = r_meas_grp;
  assign bus.meas_timeout = r_meas_to;

endmodule
`default_nettype wire

// File: tb/tb_sonic_trigger_scheduler.sv
`default_nettype none
// ============================================================================
// Module   : tb_sonic_trigger_scheduler
// Purpose  : Self-checking bench for the trigger scheduler with short timing
//            (TRIG=4, TIMEOUT=40, GUARD=8). Expected group/status/latency is
//            queued when a trigger is seen and checked on meas_done.
// Revision : 1.0 - initial release
// ============================================================================
module tb_sonic_trigger_scheduler;

  localparam int NG      = 2;
  localparam int TRIG_C  = 4;
  localparam int TO_C    = 40;
  localparam int GUARD_C = 8;

  typedef struct {
    int grp;
    int to;
    int lat;
  } exp_t;

  logic clk;
  logic reset_n;
  int   n_checks;
  int   n_fail;
  int   model_last;
  int   last_gap;
  exp_t sb_q[$];

  sonic_trigger_scheduler_if #(.NUM_GROUPS(NG)) bus ();

  sonic_trigger_scheduler #(
    .NUM_GROUPS     (NG),
    .TRIG_CYCLES    (TRIG_C),
    .TIMEOUT_CYCLES (TO_C),
    .GUARD_CYCLES   (GUARD_C)
  ) dut (
    .CLOCK_50 (clk),
    .reset_n  (reset_n),
    .bus      (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // Reference round-robin: first set mask bit after last, wrapping
  function automatic int model_next(input int last, input logic [NG-1:0] m);
    for (int k = 1; k <= NG; k++) begin
      if (m[(last + k) % NG]) return (last + k) % NG;
    end
    return last;
  endfunction

  // Trigger must be one-hot or zero on every cycle
  always @(negedge clk) begin
    check_val("trig_onehot", ($countones(bus.trig) <= 1), 1);
  end

  // Wait for a trigger rise, counting negedges; returns the group or -1
  task automatic wait_rise(output int grp);
    int n;
    n   = 0;
    grp = -1;
    do begin
      @(negedge clk);
      n++;
    end while (bus.trig == '0 && n < 200);
    last_gap = n;
    if (bus.trig == '0) begin
      check_val("trig_rise_timeout", 0, 1);
    end else begin
      grp = (bus.trig[1]) ? 1 : 0;
    end
  endtask

  // One measurement: echo pulse from cycle s to e after trig fall (s<0: none)
  task automatic do_meas(input int s, input int e, input int exp_to, input int exp_lat,
                         input int exp_gap, input bit drop_en);
    int   g, width, c;
    exp_t ex, got;
    wait_rise(g);
    if (g < 0) return;
    if (exp_gap >= 0) check_val("guard_gap", last_gap, exp_gap);
    ex.grp     = model_next(model_last, bus.group_mask);
    model_last = ex.grp;
    ex.to      = exp_to;
    ex.lat     = exp_lat;
    sb_q.push_back(ex);
    check_val("trig_grp", g, ex.grp);
    check_val("active_grp", bus.active_grp, ex.grp);
    check_val("busy_trig", bus.busy, 1);
    if (drop_en) bus.enable = 1'b0;
    width = 0;
    while (bus.trig != '0 && width < 20) begin
      width++;
      @(negedge clk);
    end
    check_val("trig_width", width, TRIG_C);
    c = 0;
    forever begin
      if (c == s) bus.echo_any = NG'(1) << g;
      if (c == e) bus.echo_any = '0;
      if (bus.meas_done) begin
        got = sb_q.pop_front();
        check_val("meas_grp", bus.meas_grp, got.grp);
        check_val("meas_timeout", bus.meas_timeout, got.to);
        check_val("meas_latency", c, got.lat);
        break;
      end
      if (c >= 80) begin
        check_val("meas_done_timeout", 0, 1);
        break;
      end
      @(negedge clk);
      c++;
    end
    bus.echo_any = '0;
  endtask

  initial begin
    int g, trig_seen;
    n_checks       = 0;
    n_fail         = 0;
    model_last     = NG - 1;
    bus.enable     = 1'b0;
    bus.group_mask = '0;
    bus.echo_any   = '0;
    reset_n        = 1'b0;
    repeat (3) @(negedge clk);
    check_val("rst_trig", bus.trig, 0);
    check_val("rst_busy", bus.busy, 0);
    check_val("rst_done", bus.meas_done, 0);
    check_val("rst_to", bus.meas_timeout, 0);
    check_val("rst_mgrp", bus.meas_grp, 0);
    check_val("rst_agrp", bus.active_grp, 0);
    reset_n = 1'b1;
    repeat (3) @(negedge clk);
    check_val("idle_busy", bus.busy, 0);

    // Both groups, normal echo pulses: alternation 0,1,0,1 with guard gap
    bus.enable     = 1'b1;
    bus.group_mask = 2'b11;
    do_meas(5, 15, 0, 18, -1, 1'b0);
    for (int i = 0; i < 3; i++) do_meas(5, 15, 0, 18, GUARD_C + 1, 1'b0);

    // No echo: timeout exactly TO_C cycles after trig fall
    for (int i = 0; i < 2; i++) do_meas(-1, -1, 1, TO_C, GUARD_C + 1, 1'b0);

    // Echo falls on the timeout cycle: completion wins
    do_meas(0, TO_C - 3, 0, TO_C, GUARD_C + 1, 1'b0);

    // Only group 1 eligible
    bus.group_mask = 2'b10;
    for (int i = 0; i < 3; i++) do_meas(5, 15, 0, 18, GUARD_C + 1, 1'b0);

    // Enable dropped mid-trigger: finishes, then stays idle
    bus.group_mask = 2'b11;
    do_meas(5, 15, 0, 18, GUARD_C + 1, 1'b1);
    trig_seen = 0;
    repeat (30) begin
      @(negedge clk);
      if (bus.trig != '0) trig_seen++;
    end
    check_val("no_trig_disabled", trig_seen, 0);
    check_val("busy_disabled", bus.busy, 0);

    // Re-enable, then assert reset in the middle of a trigger
    bus.enable = 1'b1;
    do_meas(5, 15, 0, 18, -1, 1'b0);
    wait_rise(g);
    #2 reset_n = 1'b0;
    #1;
    check_val("rst_async_trig", bus.trig, 0);
    check_val("rst_async_busy", bus.busy, 0);
    check_val("rst_async_agrp", bus.active_grp, 0);
    @(negedge clk);
    reset_n    = 1'b1;
    model_last = NG - 1;
    sb_q.delete();
    do_meas(5, 15, 0, 18, -1, 1'b0);
    check_val("sb_empty", sb_q.size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

  // Global bound so the run always ends
  initial begin
    #500000;
    $display("FAIL watchdog: got 0 expected 1");
    $fatal(1, "watchdog expired");
  end

endmodule
`default_nettype wire

// File: doc/sonic_trigger_scheduler.md
Name: sonic_trigger_scheduler

Overview:
Round-robin scheduler for the ultrasonic sensor network. Fires one trigger group at a time, watches that group's combined echo, and enforces an echo timeout and an inter-group guard time so groups never cross-talk. Sits between the top-level sensor network and the per-sensor distance counters. Replaces the free-running fixed two-phase trigger generator with a mask-controlled, echo-aware sequencer.

Parameters:
NUM_GROUPS, 2, number of trigger groups (>=1)
TRIG_CYCLES, 500, trigger high time in clocks (10 us at 50 MHz)
TIMEOUT_CYCLES, 1500000, max clocks from trigger fall to echo fall (30 ms)
GUARD_CYCLES, 500000, quiet clocks after each measurement before the next trigger (10 ms)

Ports:
CLOCK_50  in  1  system clock
reset_n  in  1  asynchronous active-low reset
enable  in  1  run scheduling; sampled at arbitration only
group_mask  in  NUM_GROUPS  1 = group eligible; sampled at arbitration only
echo_any  in  NUM_GROUPS  asynchronous OR of the echo lines in each group
trig  out  NUM_GROUPS  one-hot trigger outputs, at most one bit high
active_grp  out  CW=max(1,$clog2(NUM_GROUPS))  group currently being served
busy  out  1  high in any state except IDLE
meas_done  out  1  one-cycle strobe at end of a group's measurement
meas_grp  out  CW  group for meas_done, held until next strobe
meas_timeout  out  1  valid with meas_done: 1 = timed out, 0 = echo completed

Behaviour:
- Reset (async assert, sync release): state IDLE; trig=0, busy=0, meas_done=0, meas_timeout=0, meas_grp=0, active_grp=0; last-served pointer = NUM_GROUPS-1 so group 0 wins first; counters and sync flops = 0. Assertion mid-trigger drops trig immediately.
- echo_any passes through a 2-flop synchronizer per bit; all echo decisions use the synced value (2-cycle latency).
- States: IDLE, TRIG, ECHO, GUARD.
- IDLE: if enable=1 and group_mask!=0, select the first set mask bit strictly after last-served, wrapping modulo NUM_GROUPS; latch into active_grp and last-served; go TRIG next cycle. Otherwise stay, trig=0.
- TRIG: trig[active_grp]=1 for exactly TRIG_CYCLES consecutive cycles; then ECHO with cycle counter cleared and seen_rise cleared.
- ECHO: counter increments every cycle. Synced echo high sets seen_rise. seen_rise=1 and synced echo low -> meas_done=1, meas_timeout=0, go GUARD. Counter reaching TIMEOUT_CYCLES-1 without completion -> meas_done=1, meas_timeout=1, go GUARD. If both happen in the same cycle, completion wins (meas_timeout=0). meas_grp is loaded with active_grp in the meas_done cycle.
- GUARD: count GUARD_CYCLES cycles, trig=0, then IDLE. A new trigger is never issued before the guard ends; echo activity during guard is ignored.
- Minimum trigger-rise-to-next-trigger-rise time: TRIG_CYCLES + measurement time + GUARD_CYCLES + 1 (IDLE cycle).
- enable=0 or mask changes mid-cycle: the current group finishes TRIG/ECHO/GUARD normally; the change takes effect at the next IDLE arbitration. No truncated trigger pulses.
- Single-bit mask: that group repeats back-to-back. Mask=0: stays IDLE, busy=0.
- Counter width: $clog2(max(TRIG_CYCLES,TIMEOUT_CYCLES,GUARD_CYCLES)+1); one shared down/up counter reused per state is acceptable.
- Echo already high when ECHO is entered (stuck sensor): counts as a rise; measurement completes on its fall or times out.

Decomposition:
- Package sonic_pkg: state enum (IDLE, TRIG, ECHO, GUARD), default timing constants derived from a 50 MHz clock, and a CW helper function.
- One sub-module: sonic_rr_arbiter (combinational next-group select from mask and last-served pointer, round-robin with wrap). The synchronizer stays inline.

Test Plan:
(All runs use NUM_GROUPS=2, TRIG_CYCLES=4, TIMEOUT_CYCLES=40, GUARD_CYCLES=8.)
- Reset then enable=1, mask=2'b11, echo pulse 10 cycles wide, 5 cycles after each trigger fall -> trig[0] high for 4 cycles, meas_done with grp=0 and timeout=0; 8-cycle guard; then trig[1]; groups keep alternating 0,1,0,1.
- mask=2'b11, no echo at all -> meas_done with meas_timeout=1 exactly 40 cycles after trig fall; next trigger goes to the other group.
- mask=2'b10 -> only trig[1] ever pulses; trig[0] stays 0; last-served wraps correctly.
- enable dropped in the middle of TRIG -> pulse still lasts 4 cycles; ECHO and GUARD complete; then IDLE with busy=0 and no further triggers.
- reset_n asserted during TRIG -> trig=0 in the same cycle with no clock edge; after release, first trigger goes to group 0.
- Echo falls on the timeout cycle -> meas_timeout=0; trig is one-hot or zero on every cycle (assertion).
